// File: rtl/cordic_arb_pkg.sv
// Shared types and helpers for the CORDIC magnitude arbiter.
// Holds the tag-line entry type and the requester-ID width helper.
package cordic_arb_pkg;

    localparam int CORDIC_LAT_DEFAULT = 12;
    localparam int ID_MAX_W = 4;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                vld;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/cordic_mag_arbiter_rr.sv
// Combinational round-robin picker: searches upward from ptr+1 with wrap.
// Produces a one-hot grant and its encoded index.
module rr_arbiter
    import cordic_arb_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = id_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] id_o
);

    logic found;
    int   idx;

    // First requester after the pointer, wrapping, wins
    always_comb begin
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                id_o         = W'(idx);
            end
        end
    end

endmodule

// File: rtl/cordic_mag_arbiter.sv
// Shares one pipelined CORDIC magnitude unit among N_REQ requesters.
// Optional per-requester grant counters: define CORDIC_ARB_STATS_EN.
module cordic_mag_arbiter
    import cordic_arb_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int Q_I        = 15,
    parameter  int Q_F        = 16,
    localparam int WIDTH      = Q_I + Q_F + 1,
    parameter  int CORDIC_LAT = CORDIC_LAT_DEFAULT,
    parameter  int MAX_OUTST  = 4,
    localparam int ID_W       = id_w(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] req_x_i,
    input  logic [N_REQ*WIDTH-1:0] req_y_i,
    output logic                   cordic_valid_o,
    output logic [WIDTH-1:0]       cordic_x_o,
    output logic [WIDTH-1:0]       cordic_y_o,
    input  logic                   cordic_valid_i,
    input  logic [WIDTH-1:0]       cordic_data_i,
    output logic [N_REQ-1:0]       resp_valid_o,
    output logic [WIDTH-1:0]       resp_data_o,
    output logic [ID_W-1:0]        resp_id_o,
    output logic                   err_o
`ifdef CORDIC_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]    stat_grants_o
`endif
);

    localparam int OW = $clog2(MAX_OUTST + 1);

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [OW-1:0]    outst_q [N_REQ];
    logic [OW-1:0]    outst_d [N_REQ];
    tag_t             tag_q [CORDIC_LAT];
    tag_t             tag_out;
    logic [N_REQ-1:0] ret;
    logic             underflow;
    logic             err_q, err_d;
    logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_data_q;
    logic [ID_W-1:0]  resp_id_q;

    // Requester may compete only while it has credit left
    always_comb begin
        elig = '0;
        for (int k = 0; k < N_REQ; k++) begin
            elig[k] = req_valid_i[k] && (outst_q[k] < OW'(MAX_OUTST));
        end
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req_i   (elig),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .id_o    (grant_id)
    );

    assign grant_any   = |grant;
    assign req_ready_o = grant;
    assign tag_out     = tag_q[CORDIC_LAT-1];

    // Forward winner operands; the CORDIC registers them itself
    always_comb begin
        cordic_valid_o = grant_any;
        cordic_x_o     = '0;
        cordic_y_o     = '0;
        ptr_d          = ptr_q;
        if (grant_any) begin
            cordic_x_o = req_x_i[grant_id*WIDTH +: WIDTH];
            cordic_y_o = req_y_i[grant_id*WIDTH +: WIDTH];
            ptr_d      = grant_id;
        end
    end

    // Credit update, returning-tag decode and error detection
    always_comb begin
        underflow    = 1'b0;
        ret          = '0;
        resp_valid_d = '0;
        for (int k = 0; k < N_REQ; k++) begin
            ret[k] = tag_out.vld && (tag_out.id == ID_MAX_W'(k));
            resp_valid_d[k] = ret[k] && cordic_valid_i;
            outst_d[k] = outst_q[k];
            if (grant[k] && !ret[k]) begin
                outst_d[k] = outst_q[k] + OW'(1);
            end else if (ret[k] && !grant[k]) begin
                if (outst_q[k] == '0) begin
                    underflow = 1'b1;
                end else begin
                    outst_d[k] = outst_q[k] - OW'(1);
                end
            end
        end
        err_d = err_q | underflow | (cordic_valid_i != tag_out.vld);
    end

    // Pointer, credits, tag line, response and error state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q        <= ID_W'(N_REQ - 1);
            err_q        <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            for (int k = 0; k < N_REQ; k++) outst_q[k] <= '0;
            for (int i = 0; i < CORDIC_LAT; i++) tag_q[i] <= '0;
        end else begin
            ptr_q        <= ptr_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= tag_out.id[ID_W-1:0];
            if (cordic_valid_i) resp_data_q <= cordic_data_i;
            for (int k = 0; k < N_REQ; k++) outst_q[k] <= outst_d[k];
            tag_q[0] <= '{vld: grant_any, id: ID_MAX_W'(grant_id)};
            for (int i = 1; i < CORDIC_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_id_o    = resp_id_q;
    assign err_o        = err_q;

`ifdef CORDIC_ARB_STATS_EN
    logic [15:0] stat_q [N_REQ];

    // Saturating per-requester grant counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < N_REQ; k++) stat_q[k] <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (grant[k] && stat_q[k] != 16'hFFFF) begin
                    stat_q[k] <= stat_q[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stat_grants_o = '0;
        for (int k = 0; k < N_REQ; k++) stat_grants_o[k*16 +: 16] = stat_q[k];
    end
`endif

endmodule

// File: tb/tb_cordic_mag_arbiter.sv
// Directed bench for cordic_mag_arbiter with a behavioural CORDIC model.
// Build with CORDIC_ARB_STATS_EN to also exercise the grant counters.
module tb_cordic_mag_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int LAT = 12;

    logic           clk = 0;
    logic           rst_n = 0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_x = '0;
    logic [N*W-1:0] req_y = '0;
    logic           c_vo;
    logic [W-1:0]   c_xo, c_yo;
    logic           c_vi;
    logic [W-1:0]   c_di;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_data;
    logic [1:0]     resp_id;
    logic           err;
    logic           inject = 0;
`ifdef CORDIC_ARB_STATS_EN
    logic [N*16-1:0] stats;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cordic_mag_arbiter dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_x_i        (req_x),
        .req_y_i        (req_y),
        .cordic_valid_o (c_vo),
        .cordic_x_o     (c_xo),
        .cordic_y_o     (c_yo),
        .cordic_valid_i (c_vi),
        .cordic_data_i  (c_di),
        .resp_valid_o   (resp_valid),
        .resp_data_o    (resp_data),
        .resp_id_o      (resp_id),
        .err_o          (err)
`ifdef CORDIC_ARB_STATS_EN
        ,
        .stat_grants_o  (stats)
`endif
    );

    function automatic logic [W-1:0] mag(input logic signed [W-1:0] x,
                                         input logic signed [W-1:0] y);
        real rx, ry;
        rx = $itor(x);
        ry = $itor(y);
        return W'($rtoi($sqrt(rx * rx + ry * ry) + 0.5));
    endfunction

    logic         pv [LAT];
    logic [W-1:0] pd [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= c_vo;
            pd[0] <= mag(c_xo, c_yo);
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign c_vi = pv[LAT-1] | inject;
    assign c_di = pd[LAT-1];

    function automatic bit near(input logic [W-1:0] a, input logic [W-1:0] b);
        int d;
        d = int'(a) - int'(b);
        return (d >= -4) && (d <= 4);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        req_valid = '0;
        inject = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        total++;
        if (req_ready !== '0 || resp_valid !== '0 || err !== 0 || c_vo !== 0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b resp=%b err=%b cv=%b want 0",
                     req_ready, resp_valid, err, c_vo);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL reset_ptr: ready=%b want 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        logic [N-1:0] exp_v;
        do_reset();
        req_x[0*W +: W] = 32'h0003_0000;
        req_y[0*W +: W] = 32'h0004_0000;
        for (int c = 0; c <= 20; c++) begin
            req_valid = (c == 0) ? 4'b0001 : 4'b0000;
            #1;
            if (c == 0) begin
                total++;
                if (req_ready !== 4'b0001 || c_vo !== 1 || c_xo !== 32'h0003_0000
                    || c_yo !== 32'h0004_0000) begin
                    bad++;
                    $display("FAIL single_issue: ready=%b cv=%b x=%h y=%h", req_ready,
                             c_vo, c_xo, c_yo);
                end
            end
            exp_v = (c == 13) ? 4'b0001 : 4'b0000;
            total++;
            if (resp_valid !== exp_v) begin
                bad++;
                $display("FAIL single_resp_c%0d: got %b want %b", c, resp_valid, exp_v);
            end
            if (c == 13) begin
                total++;
                if (!near(resp_data, 32'h0005_0000) || resp_id !== 2'd0) begin
                    bad++;
                    $display("FAIL single_data: got %h id %0d want 00050000 id 0",
                             resp_data, resp_id);
                end
            end
            @(negedge clk);
        end
        total++;
        if (err !== 0) begin
            bad++;
            $display("FAIL single_err: got %b want 0", err);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_g, exp_v;
        int g;
        do_reset();
        for (int k = 0; k < N; k++) begin
            req_x[k*W +: W] = W'((k + 1) << 16);
            req_y[k*W +: W] = '0;
        end
        for (int c = 0; c < 40; c++) begin
            req_valid = (c < 24) ? 4'b1111 : 4'b0000;
            #1;
            exp_g = (c < 24) ? 4'(1 << (c % 4)) : 4'b0000;
            total++;
            if (req_ready !== exp_g) begin
                bad++;
                $display("FAIL fair_grant_c%0d: got %b want %b", c, req_ready, exp_g);
            end
            g = c - 13;
            exp_v = (g >= 0 && g < 24) ? 4'(1 << (g % 4)) : 4'b0000;
            total++;
            if (resp_valid !== exp_v) begin
                bad++;
                $display("FAIL fair_resp_c%0d: got %b want %b", c, resp_valid, exp_v);
            end else if (exp_v != 0) begin
                total++;
                if (resp_id !== 2'(g % 4) || !near(resp_data, W'((g % 4 + 1) << 16))) begin
                    bad++;
                    $display("FAIL fair_data_c%0d: id %0d data %h want id %0d data %h",
                             c, resp_id, resp_data, g % 4, (g % 4 + 1) << 16);
                end
            end
            @(negedge clk);
        end
        total++;
        if (err !== 0) begin
            bad++;
            $display("FAIL fair_err: got %b want 0", err);
        end
    endtask

    task automatic test_credit_limit();
        logic [N-1:0] exp_g;
        do_reset();
        req_x[2*W +: W] = 32'h0001_0000;
        req_y[2*W +: W] = 32'h0001_0000;
        for (int c = 0; c < 20; c++) begin
            req_valid = 4'b0100;
            #1;
            exp_g = (c <= 3 || (c >= 13 && c <= 16)) ? 4'b0100 : 4'b0000;
            total++;
            if (req_ready !== exp_g) begin
                bad++;
                $display("FAIL credit_c%0d: got %b want %b", c, req_ready, exp_g);
            end
            @(negedge clk);
        end
        req_valid = '0;
`ifdef CORDIC_ARB_STATS_EN
        total++;
        if (stats[2*16 +: 16] !== 16'd8 || stats[0 +: 16] !== 16'd0) begin
            bad++;
            $display("FAIL stats: req2=%0d req0=%0d want 8 0", stats[2*16 +: 16],
                     stats[0 +: 16]);
        end
`endif
        repeat (20) @(negedge clk);
        total++;
        if (err !== 0) begin
            bad++;
            $display("FAIL credit_err: got %b want 0", err);
        end
    endtask

    task automatic test_negative();
        logic [N-1:0] exp_v;
        do_reset();
        req_x[3*W +: W] = 32'hFFFD_0000;
        req_y[3*W +: W] = 32'hFFFC_0000;
        for (int c = 0; c <= 16; c++) begin
            req_valid = (c == 0) ? 4'b1000 : 4'b0000;
            #1;
            exp_v = (c == 13) ? 4'b1000 : 4'b0000;
            total++;
            if (resp_valid !== exp_v) begin
                bad++;
                $display("FAIL neg_resp_c%0d: got %b want %b", c, resp_valid, exp_v);
            end
            if (c == 13) begin
                total++;
                if (!near(resp_data, 32'h0005_0000) || resp_id !== 2'd3) begin
                    bad++;
                    $display("FAIL neg_data: got %h id %0d want 00050000 id 3",
                             resp_data, resp_id);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req_valid = (c < 3) ? 4'b0001 : 4'b0000;
            @(negedge clk);
        end
        rst_n = 0;
        #1;
        total++;
        if (resp_valid !== '0 || err !== 0) begin
            bad++;
            $display("FAIL midrst_hold: resp=%b err=%b want 0 0", resp_valid, err);
        end
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++;
            if (resp_valid !== '0 || err !== 0) begin
                bad++;
                $display("FAIL midrst_c%0d: resp=%b err=%b want 0 0", c, resp_valid, err);
            end
        end
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_ptr: ready=%b want 0001", req_ready);
        end
        req_valid = '0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req_valid = 4'b0010;
            #1;
            total++;
            if (req_ready !== ((c < 4) ? 4'b0010 : 4'b0000)) begin
                bad++;
                $display("FAIL midrst_credit_c%0d: ready=%b", c, req_ready);
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_error();
        do_reset();
        inject = 1;
        #1;
        total++;
        if (err !== 0) begin
            bad++;
            $display("FAIL err_early: got %b want 0", err);
        end
        @(negedge clk);
        inject = 0;
        total++;
        if (err !== 1 || resp_valid !== '0) begin
            bad++;
            $display("FAIL err_set: err=%b resp=%b want 1 0000", err, resp_valid);
        end
        repeat (5) @(negedge clk);
        total++;
        if (err !== 1) begin
            bad++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        do_reset();
        total++;
        if (err !== 0) begin
            bad++;
            $display("FAIL err_clear: got %b want 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_credit_limit();
        test_negative();
        test_reset_midflight();
        test_error();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
